// File: rtl/mmio_uart_tx_if.sv
// rtl/mmio_uart_tx_if.sv - CPU store/load bus bundle for the memory-mapped UART transmitter
interface mmio_uart_tx_if;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output memwrite, output dataadr, output writedata, input readdata);
    modport slave  (input memwrite, input dataadr, input writedata, output readdata);
endinterface

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8-bit UART transmitter with TX FIFO; MMIO_UART_TX_PARITY_EN adds an even-parity bit
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic            clk,
    input  logic            reset,
    mmio_uart_tx_if.slave   bus,
    output logic            txd,
    output logic            busy,
    output logic            full
);
    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam int          CW        = AW + 1;
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [31:0] CTRL_ADDR = BASE_ADDR + 32'd4;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef MMIO_UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          empty;
    logic          overflow;

    logic [2:0]    state;
    logic [15:0]   baud;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
`ifdef MMIO_UART_TX_PARITY_EN
    logic          par;
`endif

    logic          data_wr;
    logic          ctrl_wr;
    logic          push;
    logic          drop;
    logic          pop;
    logic          baud_done;
    logic [7:0]    head;

    assign empty     = (count == '0);
    assign full      = (count == CW'(FIFO_DEPTH));
    assign busy      = (state != S_IDLE) || !empty;
    assign head      = mem[rd_ptr];
    assign baud_done = (baud == BAUD_LAST);

    always_comb begin
        data_wr = reset && bus.memwrite && (bus.dataadr == BASE_ADDR);
        ctrl_wr = reset && bus.memwrite && (bus.dataadr == CTRL_ADDR);
        push    = data_wr && !full;
        drop    = data_wr && full;
        pop     = reset && !empty &&
                  ((state == S_IDLE) || ((state == S_STOP) && baud_done));
    end

    always_comb begin
        bus.readdata = 32'b0;
        if (bus.dataadr == CTRL_ADDR)
            bus.readdata = {28'b0, overflow, full, empty, busy};
    end

    // Storage needs no reset: occupancy is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= bus.writedata[7:0];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + CW'(push) - CW'(pop);
            if (drop)
                overflow <= 1'b1;
            else if (ctrl_wr && bus.writedata[0])
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= S_IDLE;
            baud    <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            txd     <= 1'b1;
`ifdef MMIO_UART_TX_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        shreg <= head;
`ifdef MMIO_UART_TX_PARITY_EN
                        par   <= ^head;
`endif
                        txd   <= 1'b0;
                        baud  <= '0;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (baud_done) begin
                        baud    <= '0;
                        bit_cnt <= '0;
                        txd     <= shreg[0];
                        shreg   <= shreg >> 1;
                        state   <= S_DATA;
                    end else begin
                        baud <= baud + 16'd1;
                    end
                end
                S_DATA: begin
                    if (baud_done) begin
                        baud <= '0;
                        if (bit_cnt == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
                            txd   <= par;
                            state <= S_PARITY;
`else
                            txd   <= 1'b1;
                            state <= S_STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            txd     <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end else begin
                        baud <= baud + 16'd1;
                    end
                end
`ifdef MMIO_UART_TX_PARITY_EN
                S_PARITY: begin
                    if (baud_done) begin
                        baud  <= '0;
                        txd   <= 1'b1;
                        state <= S_STOP;
                    end else begin
                        baud <= baud + 16'd1;
                    end
                end
`endif
                S_STOP: begin
                    if (baud_done) begin
                        baud <= '0;
                        // Chain straight into the next start bit so frames abut.
                        if (pop) begin
                            shreg <= head;
`ifdef MMIO_UART_TX_PARITY_EN
                            par   <= ^head;
`endif
                            txd   <= 1'b0;
                            state <= S_START;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        baud <= baud + 16'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    txd   <= 1'b1;
                    baud  <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - self-checking bench for mmio_uart_tx against a bit-stream reference model
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE  = 32'hFFFF_0000;
    localparam logic [31:0] CTRL  = BASE + 32'd4;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic txd;
    logic busy;
    logic full;

    mmio_uart_tx_if bus();

    mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .bus(bus), .txd(txd), .busy(busy), .full(full)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail = 0;
    logic exp_bits[$];

    // Expected line level, one entry per clock, for a whole frame.
    function automatic void add_frame(input logic [7:0] b);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(b[i]);
`ifdef MMIO_UART_TX_PARITY_EN
        bits.push_back(^b);
`endif
        bits.push_back(1'b1);
        foreach (bits[i]) for (int c = 0; c < CPB; c++) exp_bits.push_back(bits[i]);
    endfunction

    function automatic logic [31:0] status_word(input logic ovf, input logic ful,
                                                input logic emp, input logic bsy);
        return {28'b0, ovf, ful, emp, bsy};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        bus.memwrite  = 1'b1;
        bus.dataadr   = addr;
        bus.writedata = data;
    endtask

    task automatic bus_idle();
        bus.memwrite  = 1'b0;
        bus.dataadr   = 32'h0000_1000;
        bus.writedata = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus_write(BASE, 32'h0000_005A);
        tick();
        tick();
        n_checks++; if (txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b expected 1", txd); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
        bus_idle();
        bus.dataadr = CTRL; #1;
        n_checks++; if (bus.readdata !== status_word(0, 0, 1, 0)) begin n_fail++; $display("FAIL reset_status: got %h expected %h", bus.readdata, status_word(0, 0, 1, 0)); end
        bus.dataadr = BASE; #1;
        n_checks++; if (bus.readdata !== 32'h0) begin n_fail++; $display("FAIL reset_data_read: got %h expected 0", bus.readdata); end
        reset = 1'b1;
        bus_idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (txd !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL write_in_reset: got txd=%b busy=%b expected 1/0", txd, busy); end
        end
    endtask

    task automatic test_single_frames();
        for (int rep = 0; rep < 3; rep++) begin
            logic [7:0] b;
            b = (rep == 0) ? 8'h55 : 8'($urandom);
            exp_bits.delete();
            add_frame(b);
            bus_write(BASE, {24'($urandom), b});
            tick();
            bus_idle();
            n_checks++; if (txd !== 1'b1) begin n_fail++; $display("FAIL single_pre_start: got %b expected 1", txd); end
            n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_queued: got %b expected 1", busy); end
            for (int i = 0; i < exp_bits.size(); i++) begin
                tick();
                n_checks++; if (txd !== exp_bits[i]) begin n_fail++; $display("FAIL single_txd[%0d] byte %h: got %b expected %b", i, b, txd, exp_bits[i]); end
                n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy[%0d]: got %b expected 1", i, busy); end
            end
            tick();
            n_checks++; if (txd !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL single_end: got txd=%b busy=%b expected 1/0", txd, busy); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        int pos = 0;
        exp_bits.delete();
        for (int j = 0; j < DEPTH + 1; j++) begin
            b = (j == 0) ? 8'h01 : 8'($urandom);
            add_frame(b);
            bus_write(BASE, {24'h0, b});
            tick();
            if (j > 0) begin
                n_checks++; if (txd !== exp_bits[pos]) begin n_fail++; $display("FAIL b2b_txd[%0d]: got %b expected %b", pos, txd, exp_bits[pos]); end
                pos++;
            end
        end
        bus_idle();
        n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL b2b_full: got %b expected 1", full); end
        bus.dataadr = CTRL; #1;
        n_checks++; if (bus.readdata !== status_word(0, 1, 0, 1)) begin n_fail++; $display("FAIL b2b_status: got %h expected %h", bus.readdata, status_word(0, 1, 0, 1)); end
        while (pos < exp_bits.size()) begin
            tick();
            n_checks++; if (txd !== exp_bits[pos]) begin n_fail++; $display("FAIL b2b_txd[%0d]: got %b expected %b", pos, txd, exp_bits[pos]); end
            pos++;
        end
        tick();
        n_checks++; if (txd !== 1'b1 || busy !== 1'b0 || full !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got txd=%b busy=%b full=%b expected 1/0/0", txd, busy, full); end
    endtask

    task automatic test_overflow();
        logic [7:0] b;
        int pos = 0;
        exp_bits.delete();
        for (int j = 0; j < DEPTH + 2; j++) begin
            b = 8'($urandom);
            if (j < DEPTH + 1) begin
                add_frame(b);
                bus_write(BASE, {24'h0, b});
            end else begin
                bus_write(BASE, 32'h0000_00AA);
            end
            tick();
            if (j > 0) begin
                n_checks++; if (txd !== exp_bits[pos]) begin n_fail++; $display("FAIL ovf_txd[%0d]: got %b expected %b", pos, txd, exp_bits[pos]); end
                pos++;
            end
        end
        bus_idle();
        bus.dataadr = CTRL; #1;
        n_checks++; if (bus.readdata !== status_word(1, 1, 0, 1)) begin n_fail++; $display("FAIL ovf_status_set: got %h expected %h", bus.readdata, status_word(1, 1, 0, 1)); end
        bus_write(CTRL, 32'hFFFF_FFFE);
        tick();
        n_checks++; if (txd !== exp_bits[pos]) begin n_fail++; $display("FAIL ovf_txd[%0d]: got %b expected %b", pos, txd, exp_bits[pos]); end
        pos++;
        bus_idle(); bus.dataadr = CTRL; #1;
        n_checks++; if (bus.readdata !== status_word(1, 1, 0, 1)) begin n_fail++; $display("FAIL ovf_ctrl_bit0_clear: got %h expected %h", bus.readdata, status_word(1, 1, 0, 1)); end
        bus_write(CTRL, 32'h0000_0001);
        tick();
        n_checks++; if (txd !== exp_bits[pos]) begin n_fail++; $display("FAIL ovf_txd[%0d]: got %b expected %b", pos, txd, exp_bits[pos]); end
        pos++;
        bus_idle(); bus.dataadr = CTRL; #1;
        n_checks++; if (bus.readdata !== status_word(0, 1, 0, 1)) begin n_fail++; $display("FAIL ovf_cleared: got %h expected %h", bus.readdata, status_word(0, 1, 0, 1)); end
        while (pos < exp_bits.size()) begin
            tick();
            n_checks++; if (txd !== exp_bits[pos]) begin n_fail++; $display("FAIL ovf_txd[%0d]: got %b expected %b", pos, txd, exp_bits[pos]); end
            pos++;
        end
        tick();
        n_checks++; if (txd !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL ovf_drained: got txd=%b busy=%b expected 1/0", txd, busy); end
    endtask

`ifdef MMIO_UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] vals [2];
        vals[0] = 8'h07;
        vals[1] = 8'h03;
        for (int v = 0; v < 2; v++) begin
            exp_bits.delete();
            add_frame(vals[v]);
            bus_write(BASE, {24'h0, vals[v]});
            tick();
            bus_idle();
            for (int i = 0; i < exp_bits.size(); i++) begin
                tick();
                n_checks++; if (txd !== exp_bits[i]) begin n_fail++; $display("FAIL parity_txd[%0d] byte %h: got %b expected %b", i, vals[v], txd, exp_bits[i]); end
                if (i >= 36 && i <= 39) begin
                    n_checks++; if (txd !== (v == 0)) begin n_fail++; $display("FAIL parity_bit byte %h: got %b expected %b", vals[v], txd, (v == 0)); end
                end
            end
            tick();
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL parity_end_busy: got %b expected 0", busy); end
        end
    endtask
`endif

    task automatic test_reset_mid_frame();
        int pos = 0;
        int bad = 0;
        exp_bits.delete();
        add_frame(8'h0F);
        bus_write(BASE, 32'h0000_000F);
        tick();
        for (int j = 0; j < 2; j++) begin
            bus_write(BASE, 32'($urandom_range(0, 255)));
            tick();
            n_checks++; if (txd !== exp_bits[pos]) begin n_fail++; $display("FAIL midrst_txd[%0d]: got %b expected %b", pos, txd, exp_bits[pos]); end
            pos++;
        end
        bus_idle();
        for (int i = 0; i < 3 * CPB; i++) begin
            tick();
            n_checks++; if (txd !== exp_bits[pos]) begin n_fail++; $display("FAIL midrst_txd[%0d]: got %b expected %b", pos, txd, exp_bits[pos]); end
            pos++;
        end
        reset = 1'b0;
        bus_write(BASE, 32'h0000_0033);
        tick();
        bus_idle();
        n_checks++; if (txd !== 1'b1) begin n_fail++; $display("FAIL midrst_txd_abort: got %b expected 1", txd); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        bus.dataadr = CTRL; #1;
        n_checks++; if (bus.readdata !== status_word(0, 0, 1, 0)) begin n_fail++; $display("FAIL midrst_status: got %h expected %h", bus.readdata, status_word(0, 0, 1, 0)); end
        reset = 1'b1;
        for (int i = 0; i < 15 * CPB; i++) begin
            tick();
            if (txd !== 1'b1 || busy !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL midrst_no_followup: got %0d active cycles expected 0", bad); end
    endtask

    task automatic test_ignored_addr();
        int bad = 0;
        bus_write(BASE + 32'd8, 32'($urandom));
        tick();
        bus_write(32'h0, 32'($urandom));
        tick();
        bus_write(BASE + 32'd1, 32'($urandom));
        tick();
        bus_idle();
        for (int i = 0; i < 4 * CPB; i++) begin
            tick();
            if (txd !== 1'b1 || busy !== 1'b0) bad++;
        end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL ignored_txd_idle: got %0d active cycles expected 0", bad); end
        bus.dataadr = CTRL; #1;
        n_checks++; if (bus.readdata !== status_word(0, 0, 1, 0)) begin n_fail++; $display("FAIL ignored_status: got %h expected %h", bus.readdata, status_word(0, 0, 1, 0)); end
        bus.dataadr = BASE + 32'd8; #1;
        n_checks++; if (bus.readdata !== 32'h0) begin n_fail++; $display("FAIL ignored_read_other: got %h expected 0", bus.readdata); end
    endtask

    initial begin
        bus_idle();
        test_reset();
        test_single_frames();
        test_back_to_back();
        test_overflow();
`ifdef MMIO_UART_TX_PARITY_EN
        test_parity();
`endif
        test_reset_mid_frame();
        test_ignored_addr();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
